// File: rtl/out_port_fifo.sv
// First-word-fall-through output-port FIFO that drops words on overflow instead of stalling the core.
// Define OUT_PORT_DROP_CNT_EN to add the saturating dropped-push counter on o_drop_cnt.
module out_port_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_out_write,
  input  logic [DATA_W-1:0] i_out_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_ovf_clr
`ifdef OUT_PORT_DROP_CNT_EN
  ,
  output logic [7:0]        o_drop_cnt
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so their difference is the occupancy.
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              drop;

  assign count   = wr_ptr - rd_ptr;
  assign o_count = count;
  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign o_valid = !o_empty;
  assign o_data  = mem[rd_ptr[ADDR_W-1:0]];

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  always_comb begin
    pop  = o_valid & i_ready;
    push = i_out_write & (!o_full | pop);
    drop = i_out_write & o_full & !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_out_data;
    end
  end

  // Sticky loss flag; a drop in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           o_overflow <= 1'b0;
    else if (drop)      o_overflow <= 1'b1;
    else if (i_ovf_clr) o_overflow <= 1'b0;
  end

`ifdef OUT_PORT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             o_drop_cnt <= 8'd0;
    else if (i_ovf_clr)                   o_drop_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed vector table, corner-case sequences and a random run
// checked against a queue-based reference model.
module tb_out_port_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_write;
  logic [15:0] out_data;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        ovf_clr;
`ifdef OUT_PORT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_port_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .i_out_write(out_write),
    .i_out_data (out_data),
    .o_valid    (valid),
    .o_data     (data),
    .i_ready    (ready),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (overflow),
    .i_ovf_clr  (ovf_clr)
`ifdef OUT_PORT_DROP_CNT_EN
    ,
    .o_drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [15:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic wr, input logic [15:0] din, input logic rdy, input logic clr);
    out_write = wr;
    out_data  = din;
    ready     = rdy;
    ovf_clr   = clr;
  endtask

  task automatic do_reset();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #7;
    rst = 1'b1;
    step();
  endtask

  // Reference model: a plain queue plus loss bookkeeping.
  logic [15:0] q[$];
  logic        m_ovf;
  int          m_drops;

  task automatic model_edge(input logic wr, input logic [15:0] din, input logic rdy, input logic clr);
    bit was_full;
    bit popped;
    bit dropped;
    was_full = (q.size() == 4);
    popped   = (q.size() > 0) && rdy;
    dropped  = wr && was_full && !popped;
    if (popped) void'(q.pop_front());
    if (wr && !dropped) q.push_back(din);
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drops = dropped ? 1 : 0;
    else if (dropped && m_drops < 255) m_drops++;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, valid, q.size() > 0);
    chk({tag, "_count"}, count, q.size());
    chk({tag, "_full"}, full, q.size() == 4);
    chk({tag, "_empty"}, empty, q.size() == 0);
    chk({tag, "_ovf"}, overflow, m_ovf);
    if (q.size() > 0) chk({tag, "_data"}, data, q[0]);
`ifdef OUT_PORT_DROP_CNT_EN
    chk({tag, "_dropcnt"}, drop_cnt, m_drops);
`endif
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b0, 16'h0, 1'b0, 1'b0);

    // wr din rdy clr | valid data cnt ovf
    tbl[0]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF, 3'd1, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd2, 1'b0};
    tbl[4]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd3, 1'b0};
    tbl[5]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd4, 1'b0};
    tbl[6]  = '{1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd4, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd4, 1'b0};
    tbl[8]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0002, 3'd4, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 3'd3, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004, 3'd2, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[14] = '{1'b1, 16'h0009, 1'b1, 1'b0, 1'b1, 16'h0009, 3'd1, 1'b0};

    do_reset();
    chk("rst_valid", valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_data", data, 16'h0);
    chk("rst_count", count, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
`ifdef OUT_PORT_DROP_CNT_EN
    chk("rst_dropcnt", drop_cnt, 8'd0);
`endif

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].wr, tbl[i].din, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_empty", i), empty, !tbl[i].e_valid);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].e_cnt == 3'd4);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), data, tbl[i].e_data);
    end

    // Asynchronous reset in the middle of a burst with three words queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      step();
    end
    chk("burst_count", count, 3'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_data", data, 16'h0);
    chk("async_rst_empty", empty, 1'b1);
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    set_in(1'b1, 16'h1234, 1'b0, 1'b0);
    step();
    chk("post_rst_count", count, 3'd1);
    chk("post_rst_data", data, 16'h1234);

    // Drop and clear in the same cycle: set wins.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 16'h0BAD, 1'b0, 1'b1);
    step();
    chk("clr_drop_ovf", overflow, 1'b1);
    chk("clr_drop_count", count, 3'd4);
`ifdef OUT_PORT_DROP_CNT_EN
    chk("clr_drop_cnt", drop_cnt, 8'd1);
`endif
    set_in(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    chk("clr_only_ovf", overflow, 1'b0);
`ifdef OUT_PORT_DROP_CNT_EN
    chk("clr_only_cnt", drop_cnt, 8'd0);
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, 16'(i), 1'b0, 1'b0);
      step();
    end
    chk("sat_cnt", drop_cnt, 8'd255);
    chk("sat_ovf", overflow, 1'b1);
    set_in(1'b1, 16'h0, 1'b0, 1'b1);
    step();
    chk("sat_clr_drop_cnt", drop_cnt, 8'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 16'h0, 1'b1, 1'b0);
      step();
      chk($sformatf("drain_after_drop%0d", i), count, 3'(3 - i));
    end

    // Randomised traffic against the queue model.
    do_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    for (int i = 0; i < 600; i++) begin
      logic        wr;
      logic        rdy;
      logic        clr;
      logic [15:0] din;
      wr  = ($urandom_range(0, 99) < 65);
      rdy = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 5);
      din = 16'($urandom);
      set_in(wr, din, rdy, clr);
      model_edge(wr, din, rdy, clr);
      step();
      model_check($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
